trap_controller: RTL
====================

Name: trap_controller

Overview:
- Sequences machine-mode system instructions and external interrupts for the single-issue RV32I core.
- Consumes the decoder's ecall/ebreak/mret/wfi strobes. Stalls and drains the pipeline, then updates trap state (MEPC, MCAUSE, MIE/MPIE) and redirects the fetch PC.
- Sits between the control unit decode outputs and the PC/fetch mux.

Parameters:
- XLEN, 32, width of PC, MEPC, MTVEC and MCAUSE.
- IRQ_CAUSE, 32'h8000000B, MCAUSE value for a machine external interrupt.

Ports:
- CLK  input  1  core clock; all state updates on the rising edge.
- RESET_N  input  1  synchronous reset, active low.
- ISSUE_VALID  input  1  the instruction at decode is valid and about to issue.
- PC  input  XLEN  PC of the instruction at decode.
- ECALL  input  1  decoded ecall.
- EBREAK  input  1  decoded ebreak.
- MRET  input  1  decoded mret.
- WFI  input  1  decoded wfi.
- IRQ_PENDING  input  1  level-sensitive external interrupt request.
- PIPE_IDLE  input  1  all older instructions have retired (memory and writeback empty).
- MTVEC  input  XLEN  trap vector base; bits [1:0] are ignored.
- MEPC_WE  input  1  CSR write strobe for MEPC.
- MEPC_WDATA  input  XLEN  CSR write data for MEPC.
- STALL  output  1  hold fetch and decode.
- FLUSH  output  1  kill all in-flight instructions younger than the trap point.
- PC_REDIRECT  output  1  load REDIRECT_PC into the fetch PC.
- REDIRECT_PC  output  XLEN  redirect target.
- MEPC  output  XLEN  machine exception PC.
- MCAUSE  output  XLEN  machine cause.
- MIE  output  1  global interrupt enable.
- SLEEPING  output  1  core is in the WFI sleep state.

Behaviour:
- Reset: when RESET_N=0 at a clock edge, regardless of state:
  - state <= IDLE
  - MEPC, MCAUSE, saved PC, target register <= 0
  - MIE, MPIE <= 0
  - no redirect or flush is issued.
- Request detection, IDLE state only:
  - take = ISSUE_VALID & (IRQ_PENDING&MIE | EBREAK | ECALL | MRET | WFI).
  - Priority: IRQ > EBREAK > ECALL > MRET > WFI. Lower-priority strobes in the same cycle are ignored.
- STALL = take | (state != IDLE). It is combinational, so the requesting instruction does not advance in its own cycle.
- On take: latch PC into the saved PC, latch the request kind and cause (IRQ=IRQ_CAUSE, EBREAK=3, ECALL=11), and go to DRAIN.
- DRAIN:
  - STALL=1; PIPE_IDLE is sampled every cycle, including the first.
  - When PIPE_IDLE=1: IRQ/EBREAK/ECALL go to TRAP, MRET goes to RETURN, WFI goes to SLEEP.
- TRAP, one cycle:
  - FLUSH=1, PC_REDIRECT=1, REDIRECT_PC={MTVEC[XLEN-1:2],2'b00}.
  - Next edge: MEPC<=target, MCAUSE<=cause, MPIE<=MIE, MIE<=0; go to IDLE.
  - Target is the saved PC for IRQ/ECALL/EBREAK, and saved PC+4 for a WFI wake.
- RETURN, one cycle:
  - FLUSH=1, PC_REDIRECT=1, REDIRECT_PC=MEPC.
  - Next edge: MIE<=MPIE, MPIE<=1; go to IDLE.
- SLEEP:
  - STALL=1, SLEEPING=1.
  - IRQ_PENDING=1 with MIE=1: go to TRAP, target = saved PC+4, cause = IRQ_CAUSE.
  - IRQ_PENDING=1 with MIE=0: go to RESUME.
- RESUME, one cycle:
  - FLUSH=1, PC_REDIRECT=1, REDIRECT_PC = saved PC+4, MIE unchanged; go to IDLE.
- Latency: request at cycle N with PIPE_IDLE=1 gives DRAIN at N+1, then TRAP/RETURN redirect at N+2; the state is IDLE again at N+3.
- Arithmetic: PC+4 is modulo 2^XLEN (0xFFFFFFFC+4 = 0).
- MEPC write:
  - MEPC_WE updates MEPC only when state is IDLE or DRAIN.
  - A write in the same cycle as the TRAP update is dropped; the trap wins.
  - A RETURN issued after a write in DRAIN uses the written value.
- Outside their defined states, FLUSH, PC_REDIRECT and SLEEPING are 0, and REDIRECT_PC is 0.
- IRQ_PENDING without MIE never causes a take from IDLE.
- Requests while not in IDLE are ignored; decode is stalled, so strobes must be re-presented.

Test Plan:
- Reset: hold RESET_N=0 for 2 cycles, then release -> all outputs 0 and state IDLE. Assert RESET_N=0 in DRAIN -> next cycle STALL=0 with no redirect.
- ECALL at PC=0x100, MTVEC=0x203, PIPE_IDLE=1 -> STALL high at N, REDIRECT_PC=0x200 with FLUSH at N+2, then MEPC=0x100, MCAUSE=11, MIE=0.
- EBREAK and ECALL together with PIPE_IDLE held 0 for 3 cycles -> STALL for 5 cycles, MCAUSE=3.
- MRET with MEPC=0x104 and MPIE=1 -> REDIRECT_PC=0x104 at N+2, then MIE=1 and MPIE=1.
- WFI at PC=0x300, MIE=1, IRQ after 10 cycles -> SLEEPING for those 10 cycles, then TRAP with MEPC=0x304 and MCAUSE=0x8000000B. Repeat with MIE=0 -> RESUME with REDIRECT_PC=0x304.
- IRQ_PENDING, MIE=1 and ECALL together at PC=0x40 -> interrupt wins (MCAUSE=0x8000000B, MEPC=0x40). A MEPC_WE in the same cycle as TRAP is discarded.

Source files
------------

// File: rtl/trap_controller.sv
// trap_controller: sequences ecall/ebreak/mret/wfi and machine external interrupts
// for the single-issue RV32I core. A request stalls decode, waits for older
// instructions to drain, then updates trap state and redirects fetch.
//
// Ports:
//   CLK, RESET_N          clock, synchronous active-low reset
//   ISSUE_VALID, PC       decode-stage instruction valid and its PC
//   ECALL/EBREAK/MRET/WFI decoded system-instruction strobes
//   IRQ_PENDING           level-sensitive machine external interrupt
//   PIPE_IDLE             all older instructions have retired
//   MTVEC                 trap vector base (bits [1:0] ignored)
//   MEPC_WE, MEPC_WDATA   CSR write port for MEPC
//   STALL, FLUSH          hold fetch/decode, kill younger instructions
//   PC_REDIRECT, REDIRECT_PC  fetch PC load strobe and target
//   MEPC, MCAUSE, MIE     trap CSR state
//   SLEEPING              core parked in WFI
module trap_controller #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] IRQ_CAUSE = 32'h8000000B
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            ISSUE_VALID,
    input  logic [XLEN-1:0] PC,
    input  logic            ECALL,
    input  logic            EBREAK,
    input  logic            MRET,
    input  logic            WFI,
    input  logic            IRQ_PENDING,
    input  logic            PIPE_IDLE,
    input  logic [XLEN-1:0] MTVEC,
    input  logic            MEPC_WE,
    input  logic [XLEN-1:0] MEPC_WDATA,
    output logic            STALL,
    output logic            FLUSH,
    output logic            PC_REDIRECT,
    output logic [XLEN-1:0] REDIRECT_PC,
    output logic [XLEN-1:0] MEPC,
    output logic [XLEN-1:0] MCAUSE,
    output logic            MIE,
    output logic            SLEEPING
);

    typedef enum logic [2:0] {
        StIdle, StDrain, StTrap, StReturn, StSleep, StResume
    } state_e;

    typedef enum logic [2:0] {
        KindIrq, KindEbreak, KindEcall, KindMret, KindWfi
    } kind_e;

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    kind_e           req_kind;
    logic [XLEN-1:0] req_cause;
    logic [XLEN-1:0] saved_pc_q, saved_pc_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic            irq_req;
    logic            take;
    logic [XLEN-1:0] saved_pc_plus4;
    logic            unused_mtvec_lsbs;

    assign unused_mtvec_lsbs = ^MTVEC[1:0];
    assign saved_pc_plus4    = saved_pc_q + XLEN'(4);
    assign irq_req           = IRQ_PENDING & mie_q;

    // Priority pick among simultaneous strobes: IRQ > EBREAK > ECALL > MRET > WFI.
    always_comb begin
        req_kind  = KindWfi;
        req_cause = '0;
        if (irq_req) begin
            req_kind  = KindIrq;
            req_cause = IRQ_CAUSE;
        end else if (EBREAK) begin
            req_kind  = KindEbreak;
            req_cause = XLEN'(3);
        end else if (ECALL) begin
            req_kind  = KindEcall;
            req_cause = XLEN'(11);
        end else if (MRET) begin
            req_kind = KindMret;
        end
        take = (state_q == StIdle) & ISSUE_VALID & (irq_req | EBREAK | ECALL | MRET | WFI);
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        saved_pc_d  = saved_pc_q;
        target_d    = target_q;
        cause_d     = cause_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mie_d       = mie_q;
        mpie_d      = mpie_q;
        STALL       = take | (state_q != StIdle);
        FLUSH       = 1'b0;
        PC_REDIRECT = 1'b0;
        REDIRECT_PC = '0;
        SLEEPING    = 1'b0;

        // CSR writes are only accepted before the trap update can collide with them.
        if (MEPC_WE && (state_q == StIdle || state_q == StDrain)) begin
            mepc_d = MEPC_WDATA;
        end

        case (state_q)
            StIdle: begin
                if (take) begin
                    kind_d     = req_kind;
                    saved_pc_d = PC;
                    target_d   = PC;
                    cause_d    = req_cause;
                    state_d    = StDrain;
                end
            end
            StDrain: begin
                if (PIPE_IDLE) begin
                    case (kind_q)
                        KindMret: state_d = StReturn;
                        KindWfi:  state_d = StSleep;
                        default:  state_d = StTrap;
                    endcase
                end
            end
            StTrap: begin
                FLUSH       = 1'b1;
                PC_REDIRECT = 1'b1;
                REDIRECT_PC = {MTVEC[XLEN-1:2], 2'b00};
                mepc_d      = target_q;
                mcause_d    = cause_q;
                mpie_d      = mie_q;
                mie_d       = 1'b0;
                state_d     = StIdle;
            end
            StReturn: begin
                FLUSH       = 1'b1;
                PC_REDIRECT = 1'b1;
                REDIRECT_PC = mepc_q;
                mie_d       = mpie_q;
                mpie_d      = 1'b1;
                state_d     = StIdle;
            end
            StSleep: begin
                SLEEPING = 1'b1;
                if (IRQ_PENDING) begin
                    if (mie_q) begin
                        // Interrupt wakes WFI: trap returns to the instruction after the wfi.
                        target_d = saved_pc_plus4;
                        cause_d  = IRQ_CAUSE;
                        state_d  = StTrap;
                    end else begin
                        state_d = StResume;
                    end
                end
            end
            StResume: begin
                FLUSH       = 1'b1;
                PC_REDIRECT = 1'b1;
                REDIRECT_PC = saved_pc_plus4;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            kind_q     <= KindIrq;
            saved_pc_q <= '0;
            target_q   <= '0;
            cause_q    <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            saved_pc_q <= saved_pc_d;
            target_q   <= target_d;
            cause_q    <= cause_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
        end
    end

    assign MEPC   = mepc_q;
    assign MCAUSE = mcause_q;
    assign MIE    = mie_q;

endmodule
